counter_updown: RTL and testbench

Parametrised modulo counter for control and address sequencing. It counts up or down by a runtime step, against a runtime modulus that falls back to a compile-time default. It supports wrap or saturate mode, reports wrap, zero and terminal-count status, and has an optional output delay line. It is the general-purpose replacement for the fixed up-by-one modulo counter used in the pipeline and test-vector sequencing logic.

---
 rtl/counter_updown_pkg.sv | 20 ++
 rtl/counter_updown_if.sv | 27 ++
 rtl/counter_updown_nextval.sv | 53 +++++
 rtl/counter_updown.sv | 102 ++++++++++
 tb/tb_counter_updown.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/counter_updown_pkg.sv
// Shared definitions for the up/down modulo counter family: overflow policy
// encoding and the width helper used to size counters from their modulus.
package counter_updown_pkg;

  typedef enum logic {
    COUNTER_WRAP     = 1'b0,
    COUNTER_SATURATE = 1'b1
  } counter_policy_e;

  // Ceiling log2 with a floor of 1, so a modulus of 2**n needs n bits.
  function automatic int util_math_log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_updown_if.sv
// Control and status bundle of counter_updown: load/count controls in,
// count value and status flags out.
interface counter_updown_if #(
  parameter int WIDTH      = 4,
  parameter int STEP_WIDTH = WIDTH
);
  logic [WIDTH-1:0]      d;
  logic                  load;
  logic                  enable;
  logic                  down;
  logic [STEP_WIDTH-1:0] step;
  logic [WIDTH-1:0]      limit;
  logic [WIDTH-1:0]      q;
  logic                  wrap;
  logic                  zero;
  logic                  term;

  modport master (
    output d, load, enable, down, step, limit,
    input  q, wrap, zero, term
  );

  modport slave (
    input  d, load, enable, down, step, limit,
    output q, wrap, zero, term
  );
endinterface

// File: rtl/counter_updown_nextval.sv
// Combinational next-count unit: one count/step/modulus/direction/policy in,
// next count and wrap event out. Shared by future counters.
module counter_updown_nextval
  import counter_updown_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH:0]   m,
  input  logic             down,
  input  counter_policy_e  policy,
  output logic [WIDTH-1:0] next,
  output logic             wrap
);

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] s_ext;
  logic [WIDTH:0] sum;
  logic           sat;

  // NOTE: every output gets a default first so no path through the if-chain
  // leaves a value unassigned and infers a latch.
  always_comb begin
    cnt_ext = {1'b0, count};
    s_ext   = {1'b0, s};
    sum     = cnt_ext + s_ext;
    sat     = (policy == COUNTER_SATURATE);
    next    = count;
    wrap    = 1'b0;

    if (cnt_ext >= m) begin
      // Stale state after the modulus shrank: snap back into range, no step.
      wrap = 1'b1;
      next = sat ? WIDTH'(m - ONE) : '0;
    end else if (!down) begin
      if (sum < m) begin
        next = WIDTH'(sum);
      end else begin
        wrap = 1'b1;
        next = sat ? WIDTH'(m - ONE) : WIDTH'(sum - m);
      end
    end else if (cnt_ext >= s_ext) begin
      next = WIDTH'(cnt_ext - s_ext);
    end else begin
      wrap = 1'b1;
      next = sat ? '0 : WIDTH'(cnt_ext + m - s_ext);
    end
  end

endmodule

// File: rtl/counter_updown.sv
// Up/down modulo counter with runtime step and modulus, wrap or saturate
// policy, wrap/zero/terminal-count status and an aligned output delay line.
module counter_updown
  import counter_updown_pkg::*;
#(
  parameter int MAX        = 16,
  parameter int WIDTH      = util_math_log2(MAX),
  parameter int STEP_WIDTH = WIDTH,
  parameter int SATURATE   = 0,
  parameter int DELAY      = 0
) (
  input logic             clk,
  input logic             rst,
  counter_updown_if.slave bus
);

  localparam counter_policy_e POLICY = (SATURATE != 0) ? COUNTER_SATURATE : COUNTER_WRAP;
  // MAX == 2**WIDTH needs the extra bit; it would alias to 0 otherwise.
  localparam logic [WIDTH:0]  MAX_M  = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]  ONE    = (WIDTH+1)'(1);
  localparam int              BW     = WIDTH + 3;

  logic [WIDTH:0]   m;
  logic [WIDTH:0]   m_last;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             wrap_r;
  logic             zero_i;
  logic             term_i;
  logic [BW-1:0]    stage_in;
  logic [BW-1:0]    stage_out;

  always_comb begin
    m        = (bus.limit != '0) ? {1'b0, bus.limit} : MAX_M;
    m_last   = m - ONE;
    step_ext = (WIDTH+1)'(bus.step);
    s_eff    = (step_ext < m_last) ? WIDTH'(step_ext) : WIDTH'(m_last);
    load_val = ({1'b0, bus.d} < m) ? bus.d : WIDTH'(m_last);
  end

  counter_updown_nextval #(
    .WIDTH (WIDTH)
  ) u_nextval (
    .count  (count),
    .s      (s_eff),
    .m      (m),
    .down   (bus.down),
    .policy (POLICY),
    .next   (count_nxt),
    .wrap   (wrap_nxt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wrap_r <= 1'b0;
    end else if (bus.load) begin
      count  <= load_val;
      wrap_r <= 1'b0;
    end else if (bus.enable) begin
      count  <= count_nxt;
      wrap_r <= wrap_nxt;
    end else begin
      wrap_r <= 1'b0;
    end
  end

  assign zero_i   = (count == '0);
  assign term_i   = bus.down ? zero_i : ({1'b0, count} == m_last);
  assign stage_in = {count, wrap_r, zero_i, term_i};

  if (DELAY == 0) begin : g_nodelay
    assign stage_out = stage_in;
  end else begin : g_delay
    logic [BW-1:0] pipe [DELAY];

    // NOTE: the delay stages are cleared on reset (unlike a plain data RAM)
    // so no stale count or flag emerges after reset is released.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= stage_in;
        for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign stage_out = pipe[DELAY-1];
  end

  assign bus.q    = stage_out[BW-1:3];
  assign bus.wrap = stage_out[2];
  assign bus.zero = stage_out[1];
  assign bus.term = stage_out[0];

endmodule

// File: tb/tb_counter_updown.sv
// Directed scoreboard bench for counter_updown: wrap, saturate, large-modulus
// and delayed variants share one stimulus stream.
module tb_counter_updown;
  import counter_updown_pkg::*;

  localparam int W = 4;

  typedef struct {
    int          dut;
    string       tag;
    logic [6:0]  exp;
  } sb_t;

  logic         clk    = 1'b0;
  logic         clk_en = 1'b1;
  logic         rst    = 1'b0;
  logic [W-1:0] d;
  logic         load;
  logic         enable;
  logic         down;
  logic [W-1:0] step;
  logic [W-1:0] limit;

  logic [6:0]   obs [4];
  sb_t          sb [$];
  logic [6:0]   dq [$];
  logic [6:0]   mask = 7'b1111101;
  int           tests = 0;
  int           fails = 0;

  always #5 if (clk_en) clk = ~clk;

  counter_updown_if #(.WIDTH(W)) bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_bus
    assign bus[g].d      = d;
    assign bus[g].load   = load;
    assign bus[g].enable = enable;
    assign bus[g].down   = down;
    assign bus[g].step   = step;
    assign bus[g].limit  = limit;
    assign obs[g]        = {bus[g].q, bus[g].wrap, bus[g].zero, bus[g].term};
  end

  counter_updown #(.MAX(10))                u_a (.clk(clk), .rst(rst), .bus(bus[0]));
  counter_updown #(.MAX(16))                u_b (.clk(clk), .rst(rst), .bus(bus[1]));
  counter_updown #(.MAX(10), .SATURATE(1))  u_c (.clk(clk), .rst(rst), .bus(bus[2]));
  counter_updown #(.MAX(10), .DELAY(2))     u_d (.clk(clk), .rst(rst), .bus(bus[3]));

  function automatic logic [6:0] pk(input int qv, input logic w, input logic z, input logic t);
    logic [3:0] q4;
    q4 = qv[3:0];
    return {q4, w, z, t};
  endfunction

  task automatic check(input string tag, input logic [6:0] o, input logic [6:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed q=%0d wrap=%b zero=%b term=%b, expected q=%0d wrap=%b zero=%b term=%b",
             tag, o[6:3], o[2], o[1], o[0], e[6:3], e[2], e[1], e[0]);
    end
  endtask

  task automatic expect_out(input int dut, input string tag, input logic [6:0] e);
    sb.push_back('{dut, tag, e});
  endtask

  // One clock: outputs are sampled on the falling edge, then the scoreboard drains.
  task automatic tick();
    sb_t x;
    @(posedge clk);
    @(negedge clk);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check(x.tag, obs[x.dut], x.exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    d = '0; load = 1'b0; enable = 1'b0; down = 1'b0; step = 4'd1; limit = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_a", obs[0], pk(0, 1'b0, 1'b1, 1'b0));
    check("reset_b", obs[1], pk(0, 1'b0, 1'b1, 1'b0));
    check("reset_c", obs[2], pk(0, 1'b0, 1'b1, 1'b0));
    limit = 4'd1;
    #1 check("reset_m1_term", obs[0], pk(0, 1'b0, 1'b1, 1'b1));
    limit = '0;
    rst = 1'b0;

    // Up by one through MAX=10, with the DELAY=2 copy checked two cycles late.
    enable = 1'b1;
    dq.push_back(pk(0, 1'b0, 1'b1, 1'b0));
    for (int k = 1; k <= 12; k++) begin
      int         qv;
      logic [6:0] e;
      logic [6:0] de;
      if (k == 11) enable = 1'b0;
      qv = (k >= 10) ? 0 : k;
      e  = pk(qv, k == 10, qv == 0, qv == 9);
      expect_out(0, "up_mod10", e);
      dq.push_back(e);
      tick();
      if (k >= 2) begin
        de = dq.pop_front();
        check("delay2", obs[3] & mask, de & mask);
      end
    end

    // Down by three against limit=10, then step=0 holds.
    do_reset();
    limit = 4'd10; step = 4'd3; down = 1'b1; enable = 1'b1;
    expect_out(0, "down_wrap", pk(7, 1'b1, 1'b0, 1'b0)); tick();
    expect_out(0, "down",      pk(4, 1'b0, 1'b0, 1'b0)); tick();
    expect_out(0, "down",      pk(1, 1'b0, 1'b0, 1'b0)); tick();
    expect_out(0, "down_wrap", pk(8, 1'b1, 1'b0, 1'b0)); tick();
    expect_out(0, "down",      pk(5, 1'b0, 1'b0, 1'b0)); tick();
    step = '0;
    expect_out(0, "step0_hold", pk(5, 1'b0, 1'b0, 1'b0)); tick();

    // Saturate mode: clamp at 9 repeatedly, then clamp at 0 going down.
    do_reset();
    limit = '0; step = 4'd4; down = 1'b0; enable = 1'b1;
    expect_out(2, "sat_up",   pk(4, 1'b0, 1'b0, 1'b0)); tick();
    expect_out(2, "sat_up",   pk(8, 1'b0, 1'b0, 1'b0)); tick();
    expect_out(2, "sat_hi",   pk(9, 1'b1, 1'b0, 1'b1)); tick();
    expect_out(2, "sat_hi",   pk(9, 1'b1, 1'b0, 1'b1)); tick();
    down = 1'b1; step = 4'd9;
    expect_out(2, "sat_dn",   pk(0, 1'b0, 1'b1, 1'b1)); tick();
    expect_out(2, "sat_lo",   pk(0, 1'b1, 1'b1, 1'b1)); tick();

    // Step larger than M-1 is clamped to M-1.
    do_reset();
    down = 1'b0; step = 4'd15;
    expect_out(0, "step_clamp",      pk(9, 1'b0, 1'b0, 1'b1)); tick();
    expect_out(0, "step_clamp_wrap", pk(8, 1'b1, 1'b0, 1'b0)); tick();

    // Load beats enable and clamps out-of-range data.
    load = 1'b1; d = 4'd12;
    expect_out(0, "load_clamp", pk(9, 1'b0, 1'b0, 1'b1)); tick();
    load = 1'b0; enable = 1'b0;
    clk_en = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_reset", obs[0], pk(0, 1'b0, 1'b1, 1'b0));
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // MAX=16 instance: full-range wrap, then limit lowered under the count.
    load = 1'b1; d = 4'd15; step = 4'd1; limit = '0;
    expect_out(1, "load15",    pk(15, 1'b0, 1'b0, 1'b1)); tick();
    load = 1'b0; enable = 1'b1;
    expect_out(1, "wrap16",    pk(0, 1'b1, 1'b1, 1'b0)); tick();
    load = 1'b1; d = 4'd12;
    expect_out(1, "load12",    pk(12, 1'b0, 1'b0, 1'b0)); tick();
    load = 1'b0; limit = 4'd5;
    expect_out(1, "oor_snap",  pk(0, 1'b1, 1'b1, 1'b0)); tick();
    expect_out(1, "after_oor", pk(1, 1'b0, 1'b0, 1'b0)); tick();
    expect_out(1, "after_oor", pk(2, 1'b0, 1'b0, 1'b0)); tick();

    // Reset mid-count restarts from 0.
    do_reset();
    expect_out(1, "restart",   pk(1, 1'b0, 1'b0, 1'b0)); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
